instruction_issuer: RTL and testbench

- Hardware host-side front end for the accelerator.
- Accepts instruction words from a host over a valid/ready stream, buffers them, and drives them one per cycle into the MasterController `instruction` input.
- For every read instruction (opcode 4'b0011), samples the controller's `dataOut` and returns `{instruction, dataOut}` on a valid/ready result stream.
- Sits between the host/DMA and the accelerator top, in place of file-driven stimulus.

---
 rtl/instruction_issuer.sv | 161 ++++++++++++++++
 tb/tb_instruction_issuer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_issuer.sv
// Host-side front end: buffers host instruction words, issues one per cycle to the
// MasterController, and returns {read instruction, dataOut} for every read.
// Optional build macro ISSUER_STATS_EN adds issuedCount/readCount statistics outputs.
module instruction_issuer #(
    parameter int depth     = 2,
    parameter int W         = 8,
    parameter int FIFO_LOG2 = 3,
    parameter int READ_LAT  = 1,
    localparam int D         = 1 << depth,
    localparam int INS_W     = (2 > depth) ? 2 : depth,
    localparam int INS_D     = (D > W) ? D : W,
    localparam int INS_WIDTH = 4 + 2 + 2 * INS_W + INS_D
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   insValid,
    input  logic [INS_WIDTH-1:0]   insData,
    output logic                   insReady,
    output logic [INS_WIDTH-1:0]   instruction,
    input  logic [W-1:0]           dataOut,
    output logic                   rdValid,
    output logic [INS_WIDTH+W-1:0] rdData,
    input  logic                   rdReady,
    output logic                   busy
`ifdef ISSUER_STATS_EN
    ,
    output logic [15:0]            issuedCount,
    output logic [15:0]            readCount
`endif
);

    // Both streams: a word transfers on a rising CLK edge where valid && ready are both
    // high; valid never depends on ready, and ready here depends only on registered counts.

    localparam int CW = FIFO_LOG2 + 1;
    localparam logic [CW-1:0] SLOTS = CW'(1 << FIFO_LOG2);
    localparam logic [CW:0] SLOTS_EXT = (CW + 1)'(1 << FIFO_LOG2);
    localparam logic [3:0] OP_READ = 4'b0011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } stateT;

    stateT state, stateNext;

    logic [INS_WIDTH-1:0] insMem [1 << FIFO_LOG2];
    logic [FIFO_LOG2-1:0] insWrPtr, insRdPtr;
    logic [CW-1:0]        insCount;
    logic                 insEmpty, insPush, insPop;
    logic [INS_WIDTH-1:0] insHead;
    logic                 headIsRead;

    logic [INS_WIDTH+W-1:0] resMem [1 << FIFO_LOG2];
    logic [FIFO_LOG2-1:0]   resWrPtr, resRdPtr;
    logic [CW-1:0]          resCount;
    logic                   resPush, resPop;

    logic [READ_LAT-1:0]  tagValid;
    logic [INS_WIDTH-1:0] tagIns [READ_LAT];
    logic [CW-1:0]        pendingReads;

    logic [CW:0] creditSum;
    logic        creditOk, doIssue, issueRead;

    assign insEmpty   = (insCount == '0);
    assign insReady   = (insCount != SLOTS);
    assign insPush    = insValid && insReady;
    assign insHead    = insMem[insRdPtr];
    assign headIsRead = (insHead[INS_WIDTH-1 -: 4] == OP_READ);

    // Credit counts reads already buffered plus reads still in flight, from registered state.
    assign creditSum = {1'b0, resCount} + {1'b0, pendingReads};
    assign creditOk  = (creditSum < SLOTS_EXT);

    assign doIssue   = !insEmpty && (state != STALL) && (!headIsRead || creditOk);
    assign issueRead = doIssue && headIsRead;
    assign insPop    = doIssue;

    assign rdValid = (resCount != '0);
    assign resPop  = rdValid && rdReady;
    assign resPush = tagValid[READ_LAT-1];
    assign rdData  = rdValid ? resMem[resRdPtr] : '0;
    assign busy    = (state != IDLE);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (!insEmpty) stateNext = (headIsRead && !creditOk) ? STALL : ISSUE;
            end
            ISSUE: begin
                if (!insEmpty && headIsRead && !creditOk)  stateNext = STALL;
                else if (insEmpty && pendingReads == '0)  stateNext = IDLE;
            end
            STALL: begin
                if (creditOk) stateNext = ISSUE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            instruction  <= '0;
            insWrPtr     <= '0;
            insRdPtr     <= '0;
            insCount     <= '0;
            resWrPtr     <= '0;
            resRdPtr     <= '0;
            resCount     <= '0;
            pendingReads <= '0;
        end else begin
            state       <= stateNext;
            instruction <= doIssue ? insHead : '0;
            if (insPush) insWrPtr <= insWrPtr + 1'b1;
            if (insPop)  insRdPtr <= insRdPtr + 1'b1;
            insCount <= insCount + CW'(insPush) - CW'(insPop);
            if (resPush) resWrPtr <= resWrPtr + 1'b1;
            if (resPop)  resRdPtr <= resRdPtr + 1'b1;
            resCount     <= resCount + CW'(resPush) - CW'(resPop);
            pendingReads <= pendingReads + CW'(issueRead) - CW'(resPush);
        end
    end

    // The tag pipeline runs alongside the instruction register; its last stage marks the
    // cycle in which dataOut belongs to that read.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tagValid <= '0;
            for (int k = 0; k < READ_LAT; k++) tagIns[k] <= '0;
        end else begin
            tagValid[0] <= issueRead;
            tagIns[0]   <= insHead;
            for (int k = 1; k < READ_LAT; k++) begin
                tagValid[k] <= tagValid[k-1];
                tagIns[k]   <= tagIns[k-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (insPush) insMem[insWrPtr] <= insData;
        if (resPush) resMem[resWrPtr] <= {tagIns[READ_LAT-1], dataOut};
    end

`ifdef ISSUER_STATS_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            issuedCount <= '0;
            readCount   <= '0;
        end else begin
            issuedCount <= issuedCount + 16'(doIssue);
            readCount   <= readCount + 16'(issueRead);
        end
    end
`endif

endmodule

// File: tb/tb_instruction_issuer.sv
// Self-checking bench for instruction_issuer: queue-based reference of issue order and
// read results, with a negedge monitor that pops and compares whatever the DUT presents.
module tb_instruction_issuer;

  localparam int INS_WIDTH = 18;
  localparam int W         = 8;
  localparam int RES_W     = INS_WIDTH + W;
  localparam int FIFO_N    = 8;

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic                 insValid;
  logic [INS_WIDTH-1:0] insData;
  logic                 insReady;
  logic [INS_WIDTH-1:0] instruction;
  logic [W-1:0]         dataOut;
  logic                 rdValid;
  logic [RES_W-1:0]     rdData;
  logic                 rdReady;
  logic                 busy;
`ifdef ISSUER_STATS_EN
  logic [15:0]          issuedCount;
  logic [15:0]          readCount;
`endif

  instruction_issuer dut (
    .CLK(CLK), .RST_N(RST_N),
    .insValid(insValid), .insData(insData), .insReady(insReady),
    .instruction(instruction), .dataOut(dataOut),
    .rdValid(rdValid), .rdData(rdData), .rdReady(rdReady),
    .busy(busy)
`ifdef ISSUER_STATS_EN
    , .issuedCount(issuedCount), .readCount(readCount)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Controller model: read data is a fixed function of the word in the register.
  assign dataOut = instruction[7:0] ^ 8'hA0;

  // ---------------- scoreboard ----------------
  logic [INS_WIDTH-1:0] ins_exp_q[$];
  logic [RES_W-1:0]     exp_q[$];
  int                   issue_cyc_q[$];
  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;
  int pop_cnt = 0;
  int last_issue_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [RES_W-1:0] exp_result(input logic [INS_WIDTH-1:0] w);
    logic [W-1:0] d;
    d = w[7:0] ^ 8'hA0;
    return {w, d};
  endfunction

  function automatic logic [INS_WIDTH-1:0] mk_word(input bit is_read);
    logic [3:0] op;
    op = is_read ? 4'b0011 : 4'($urandom_range(4, 15));
    return {op, 14'($urandom)};
  endfunction

  always @(negedge CLK) begin
    if (RST_N) begin
      if (instruction != '0) begin
        issue_cnt++;
        last_issue_cyc = cyc;
        issue_cyc_q.push_back(cyc);
        if (ins_exp_q.size() == 0) check("issue_unexpected", instruction, '0);
        else check("issue_order", instruction, ins_exp_q.pop_front());
      end
      if (rdValid) begin
        if (exp_q.size() == 0) check("result_unexpected", rdValid, 0);
        else if (rdReady) begin
          pop_cnt++;
          check("result_data", rdData, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [INS_WIDTH-1:0] w, output bit ok);
    insValid = 1'b1;
    insData  = w;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge CLK);
      if (insReady) begin
        @(posedge CLK);
        ok = 1'b1;
        break;
      end
      @(posedge CLK);
    end
    if (ok) begin
      ins_exp_q.push_back(w);
      if (w[INS_WIDTH-1 -: 4] == 4'b0011) exp_q.push_back(exp_result(w));
    end else begin
      check("push_timeout", insReady, 1);
    end
    #1;
    insValid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instruction"}, instruction, '0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_insReady"}, insReady, 1);
    check({tag, "_rdValid"}, rdValid, 0);
    check({tag, "_rdData"}, rdData, '0);
  endtask

  // ---------------- stimulus ----------------
  bit ok;
  bit held_accepted;
  bit rand_done;
  int base_issue, base_pop, pop_cyc;
  logic [INS_WIDTH-1:0] w;

  initial begin
    insValid = 1'b0;
    insData  = '0;
    rdReady  = 1'b0;
    RST_N    = 1'b0;
    tick(2);
    check_reset_outputs("reset");
    RST_N = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("idle_instruction", instruction, '0);
      check("idle_busy", busy, 0);
      check("idle_insReady", insReady, 1);
    end
    @(posedge CLK); #1;

    // Single read: issue one edge after acceptance, result one edge after issue.
    rdReady = 1'b1;
    w = 18'b0011_00_00_00_00000101;
    push(w, ok);
    @(negedge CLK);
    check("single_not_early", instruction, '0);
    @(negedge CLK);
    check("single_issue", instruction, w);
    check("single_no_early_result", rdValid, 0);
    @(negedge CLK);
    check("single_rdValid", rdValid, 1);
    check("single_rdData", rdData, {w, 8'hA5});
    tick(3);

    // Back-to-back write/read/write/read: four consecutive issues.
    base_issue = issue_cnt;
    base_pop   = pop_cnt;
    for (int i = 0; i < 4; i++) push(mk_word(i % 2 == 1), ok);
    tick(6);
    check("b2b_issues", issue_cnt - base_issue, 4);
    check("b2b_results", pop_cnt - base_pop, 2);
    check("b2b_no_gap", issue_cyc_q[issue_cyc_q.size()-1] - issue_cyc_q[issue_cyc_q.size()-4], 3);

    // Credit stall: results never drained, so exactly FIFO_N reads issue.
    rdReady = 1'b0;
    base_issue = issue_cnt;
    for (int i = 0; i < 10; i++) push(mk_word(1'b1), ok);
    tick(5);
    check("credit_issues", issue_cnt - base_issue, FIFO_N);
    @(negedge CLK);
    check("credit_stall_nop", instruction, '0);
    check("credit_busy", busy, 1);
    check("credit_rdValid", rdValid, 1);
    @(posedge CLK); #1;
    rdReady = 1'b1;
    @(posedge CLK); #1;
    pop_cyc = cyc;
    rdReady = 1'b0;
    tick(5);
    check("credit_one_more", issue_cnt - base_issue, FIFO_N + 1);
    check("credit_release_latency", (last_issue_cyc - pop_cyc) inside {[1:2]}, 1);

    // Instruction FIFO full: one blocked read plus FIFO_N-1 further words fill it.
    for (int i = 0; i < FIFO_N - 1; i++) push(mk_word(1'b0), ok);
    @(negedge CLK);
    check("full_insReady", insReady, 0);
    @(posedge CLK); #1;
    held_accepted = 1'b0;
    fork
      begin
        push(mk_word(1'b0), ok);
        held_accepted = ok;
      end
      begin
        tick(4);
        check("full_held_not_taken", held_accepted, 0);
        check("full_still_full", insReady, 0);
        rdReady = 1'b1;
      end
    join
    check("full_held_accepted", held_accepted, 1);
    tick(40);
    check("full_drain_ins", ins_exp_q.size(), 0);
    check("full_drain_res", exp_q.size(), 0);

    // Mid-operation reset with queued words and a read in flight.
    rdReady = 1'b0;
    for (int i = 0; i < FIFO_N + 4; i++) push(mk_word(1'b1), ok);
    tick(2);
    rdReady = 1'b1;
    @(posedge CLK); #1;
    rdReady = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("midreset");
    ins_exp_q.delete();
    exp_q.delete();
    @(posedge CLK); #1;
    RST_N   = 1'b1;
    rdReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("post_reset_rdValid", rdValid, 0);
      check("post_reset_instruction", instruction, '0);
    end
    @(posedge CLK); #1;

    // Randomized traffic with random host back-pressure on results.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          push(mk_word($urandom_range(0, 1) == 1), ok);
          if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          rdReady = ($urandom_range(0, 3) != 0);
          @(posedge CLK); #1;
        end
        rdReady = 1'b1;
      end
    join
    for (int t = 0; t < 500; t++) begin
      if (ins_exp_q.size() == 0 && exp_q.size() == 0) break;
      @(posedge CLK);
    end
    tick(5);
    check("random_ins_drained", ins_exp_q.size(), 0);
    check("random_res_drained", exp_q.size(), 0);
    check("random_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
